// File: rtl/otter_id_ex_if.sv
// Signal bundle between the ID/EX stage and the rest of the OTTER pipeline:
// decoded ID fields, EX/MEM/WB forwarding sources, backpressure/flush, and the ID/EX register outputs.
interface otter_id_ex_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  ID_VALID;
  logic [REG_ADDR_W-1:0] ID_RS1_ADDR;
  logic [REG_ADDR_W-1:0] ID_RS2_ADDR;
  logic                  ID_USES_RS1;
  logic                  ID_USES_RS2;
  logic [XLEN-1:0]       ID_RS1_DATA;
  logic [XLEN-1:0]       ID_RS2_DATA;
  logic [REG_ADDR_W-1:0] ID_RD_ADDR;
  logic                  ID_RD_WE;
  logic                  ID_IS_LOAD;
  logic [XLEN-1:0]       ID_PC;
  logic [XLEN-1:0]       ID_IMM;
  logic [XLEN-1:0]       EX_ALU_RESULT;
  logic [REG_ADDR_W-1:0] MEM_RD_ADDR;
  logic                  MEM_RD_WE;
  logic                  MEM_FWD_VALID;
  logic [XLEN-1:0]       MEM_FWD_DATA;
  logic [REG_ADDR_W-1:0] WB_RD_ADDR;
  logic                  WB_RD_WE;
  logic [XLEN-1:0]       WB_DATA;
  logic                  EX_READY;
  logic                  FLUSH;
  logic                  ID_STALL;
  logic                  EX_VALID;
  logic [XLEN-1:0]       EX_RS1;
  logic [XLEN-1:0]       EX_RS2;
  logic [XLEN-1:0]       EX_PC;
  logic [XLEN-1:0]       EX_IMM;
  logic [REG_ADDR_W-1:0] EX_RD_ADDR;
  logic                  EX_RD_WE;
  logic                  EX_IS_LOAD;

  modport master (
    output ID_VALID, ID_RS1_ADDR, ID_RS2_ADDR, ID_USES_RS1, ID_USES_RS2,
           ID_RS1_DATA, ID_RS2_DATA, ID_RD_ADDR, ID_RD_WE, ID_IS_LOAD, ID_PC, ID_IMM,
           EX_ALU_RESULT, MEM_RD_ADDR, MEM_RD_WE, MEM_FWD_VALID, MEM_FWD_DATA,
           WB_RD_ADDR, WB_RD_WE, WB_DATA, EX_READY, FLUSH,
    input  ID_STALL, EX_VALID, EX_RS1, EX_RS2, EX_PC, EX_IMM, EX_RD_ADDR, EX_RD_WE, EX_IS_LOAD
  );

  modport slave (
    input  ID_VALID, ID_RS1_ADDR, ID_RS2_ADDR, ID_USES_RS1, ID_USES_RS2,
           ID_RS1_DATA, ID_RS2_DATA, ID_RD_ADDR, ID_RD_WE, ID_IS_LOAD, ID_PC, ID_IMM,
           EX_ALU_RESULT, MEM_RD_ADDR, MEM_RD_WE, MEM_FWD_VALID, MEM_FWD_DATA,
           WB_RD_ADDR, WB_RD_WE, WB_DATA, EX_READY, FLUSH,
    output ID_STALL, EX_VALID, EX_RS1, EX_RS2, EX_PC, EX_IMM, EX_RD_ADDR, EX_RD_WE, EX_IS_LOAD
  );
endinterface

// File: rtl/otter_id_ex_stage.sv
// OTTER decode/register-read stage: resolves RS1/RS2 through EX > MEM > WB > regfile forwarding,
// stalls on load-use / pending MEM data, and registers the result into the ID/EX pipeline register.
module otter_id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic         CLK,
  input logic         RST,
  otter_id_ex_if.slave bus
);

  typedef struct packed {
    logic            haz;
    logic [XLEN-1:0] data;
  } opnd_t;

  logic                  vld_p1;
  logic [XLEN-1:0]       rs1_p1;
  logic [XLEN-1:0]       rs2_p1;
  logic [XLEN-1:0]       pc_p1;
  logic [XLEN-1:0]       imm_p1;
  logic [REG_ADDR_W-1:0] rd_addr_p1;
  logic                  rd_we_p1;
  logic                  is_load_p1;

  opnd_t op1_p0;
  opnd_t op2_p0;
  logic  haz_p0;

  // The first matching source wins even when its data is not ready; a stale lower-priority
  // value must never be used in its place, so a not-ready match always raises a hazard.
  function automatic opnd_t resolve(input logic [REG_ADDR_W-1:0] rs,
                                    input logic                  uses,
                                    input logic [XLEN-1:0]       rf_data);
    opnd_t r;
    r.haz  = 1'b0;
    r.data = rf_data;
    if (rs == '0) begin
      r.data = '0;
    end else if (vld_p1 && rd_we_p1 && (rd_addr_p1 == rs)) begin
      r.data = bus.EX_ALU_RESULT;
      r.haz  = uses & is_load_p1;
    end else if (bus.MEM_RD_WE && (bus.MEM_RD_ADDR == rs)) begin
      r.data = bus.MEM_FWD_DATA;
      r.haz  = uses & ~bus.MEM_FWD_VALID;
    end else if (bus.WB_RD_WE && (bus.WB_RD_ADDR == rs)) begin
      r.data = bus.WB_DATA;
    end
    return r;
  endfunction

  // Stage p0: operand resolution and hazard detection on the ID-stage instruction
  always_comb begin
    op1_p0 = resolve(bus.ID_RS1_ADDR, bus.ID_USES_RS1, bus.ID_RS1_DATA);
    op2_p0 = resolve(bus.ID_RS2_ADDR, bus.ID_USES_RS2, bus.ID_RS2_DATA);
    haz_p0 = bus.ID_VALID & (op1_p0.haz | op2_p0.haz);
  end

  assign bus.ID_STALL = ~RST & bus.ID_VALID & ~bus.FLUSH & (haz_p0 | ~bus.EX_READY);

  // Stage p1: ID/EX pipeline register
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1     <= 1'b0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      pc_p1      <= '0;
      imm_p1     <= '0;
      rd_addr_p1 <= '0;
      rd_we_p1   <= 1'b0;
      is_load_p1 <= 1'b0;
    end else if (bus.FLUSH) begin
      vld_p1 <= 1'b0;
    end else if (!bus.EX_READY) begin
      vld_p1 <= vld_p1;
    end else if (haz_p0) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1     <= bus.ID_VALID;
      rs1_p1     <= op1_p0.data;
      rs2_p1     <= op2_p0.data;
      pc_p1      <= bus.ID_PC;
      imm_p1     <= bus.ID_IMM;
      rd_addr_p1 <= bus.ID_RD_ADDR;
      rd_we_p1   <= bus.ID_RD_WE;
      is_load_p1 <= bus.ID_IS_LOAD;
    end
  end

  assign bus.EX_VALID   = vld_p1;
  assign bus.EX_RS1     = rs1_p1;
  assign bus.EX_RS2     = rs2_p1;
  assign bus.EX_PC      = pc_p1;
  assign bus.EX_IMM     = imm_p1;
  assign bus.EX_RD_ADDR = rd_addr_p1;
  assign bus.EX_RD_WE   = rd_we_p1;
  assign bus.EX_IS_LOAD = is_load_p1;

endmodule

// File: tb/tb_otter_id_ex_stage.sv
// Bench for otter_id_ex_stage: directed forwarding/hazard scenarios, then randomized traffic
// checked against a priority-list reference model of the forwarding and pipeline-register rules.
module tb_otter_id_ex_stage;
  logic CLK;
  logic RST;
  int   total;
  int   bad;

  otter_id_ex_if #(.XLEN(32), .REG_ADDR_W(5)) ifc ();

  otter_id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state: the instruction the model believes sits in EX
  logic        m_vld;
  logic [31:0] m_rs1, m_rs2, m_pc, m_imm;
  logic [4:0]  m_rd;
  logic        m_we, m_ld;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    ifc.ID_VALID = 0; ifc.ID_RS1_ADDR = 0; ifc.ID_RS2_ADDR = 0;
    ifc.ID_USES_RS1 = 0; ifc.ID_USES_RS2 = 0; ifc.ID_RS1_DATA = 0; ifc.ID_RS2_DATA = 0;
    ifc.ID_RD_ADDR = 0; ifc.ID_RD_WE = 0; ifc.ID_IS_LOAD = 0; ifc.ID_PC = 0; ifc.ID_IMM = 0;
    ifc.EX_ALU_RESULT = 0; ifc.MEM_RD_ADDR = 0; ifc.MEM_RD_WE = 0; ifc.MEM_FWD_VALID = 1;
    ifc.MEM_FWD_DATA = 0; ifc.WB_RD_ADDR = 0; ifc.WB_RD_WE = 0; ifc.WB_DATA = 0;
    ifc.EX_READY = 1; ifc.FLUSH = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic u2, input logic [31:0] d2,
                        input logic [4:0] rd, input logic we, input logic ld);
    ifc.ID_VALID = 1;
    ifc.ID_RS1_ADDR = rs1; ifc.ID_USES_RS1 = u1; ifc.ID_RS1_DATA = d1;
    ifc.ID_RS2_ADDR = rs2; ifc.ID_USES_RS2 = u2; ifc.ID_RS2_DATA = d2;
    ifc.ID_RD_ADDR = rd; ifc.ID_RD_WE = we; ifc.ID_IS_LOAD = ld;
  endtask

  task automatic test_reset();
    set_idle();
    set_id(5'd1, 1, 32'h1, 5'd2, 1, 32'h2, 5'd3, 1, 1);
    ifc.EX_READY = 0;
    RST = 1;
    #1;
    total++; if (ifc.ID_STALL !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", ifc.ID_STALL); end
    tick(); tick();
    total++;
    if ({ifc.EX_VALID, ifc.EX_RS1, ifc.EX_RS2, ifc.EX_PC, ifc.EX_IMM, ifc.EX_RD_ADDR, ifc.EX_RD_WE, ifc.EX_IS_LOAD} !== '0) begin
      bad++; $display("FAIL reset_outputs got vld=%b rs1=%h pc=%h exp all zero", ifc.EX_VALID, ifc.EX_RS1, ifc.EX_PC);
    end
    RST = 0;
    set_idle();
    tick();
  endtask

  task automatic test_ex_forward();
    set_idle();
    set_id(5'd0, 0, 0, 5'd0, 0, 0, 5'd5, 1, 0);
    tick();
    ifc.EX_ALU_RESULT = 32'h10;
    set_id(5'd5, 1, 32'h0, 5'd0, 1, 32'h0, 5'd6, 1, 0);
    #1;
    total++; if (ifc.ID_STALL !== 1'b0) begin bad++; $display("FAIL exfwd_stall got=%b exp=0", ifc.ID_STALL); end
    tick();
    total++; if (ifc.EX_RS1 !== 32'h10) begin bad++; $display("FAIL exfwd_rs1 got=%h exp=00000010", ifc.EX_RS1); end
    total++; if (ifc.EX_VALID !== 1'b1) begin bad++; $display("FAIL exfwd_valid got=%b exp=1", ifc.EX_VALID); end
  endtask

  task automatic test_load_use();
    set_idle();
    set_id(5'd0, 0, 0, 5'd0, 0, 0, 5'd6, 1, 1);
    tick();
    set_id(5'd6, 1, 32'h0, 5'd0, 0, 32'h0, 5'd7, 0, 0);
    #1;
    total++; if (ifc.ID_STALL !== 1'b1) begin bad++; $display("FAIL lu_stall1 got=%b exp=1", ifc.ID_STALL); end
    tick();
    total++; if (ifc.EX_VALID !== 1'b0) begin bad++; $display("FAIL lu_bubble1 got=%b exp=0", ifc.EX_VALID); end
    ifc.MEM_RD_ADDR = 5'd6; ifc.MEM_RD_WE = 1; ifc.MEM_FWD_VALID = 0; ifc.MEM_FWD_DATA = 32'hBAD0;
    #1;
    total++; if (ifc.ID_STALL !== 1'b1) begin bad++; $display("FAIL lu_stall2 got=%b exp=1", ifc.ID_STALL); end
    tick();
    total++; if (ifc.EX_VALID !== 1'b0) begin bad++; $display("FAIL lu_bubble2 got=%b exp=0", ifc.EX_VALID); end
    ifc.MEM_FWD_VALID = 1; ifc.MEM_FWD_DATA = 32'hDEAD;
    #1;
    total++; if (ifc.ID_STALL !== 1'b0) begin bad++; $display("FAIL lu_stall3 got=%b exp=0", ifc.ID_STALL); end
    tick();
    total++; if (ifc.EX_VALID !== 1'b1) begin bad++; $display("FAIL lu_valid got=%b exp=1", ifc.EX_VALID); end
    total++; if (ifc.EX_RS1 !== 32'hDEAD) begin bad++; $display("FAIL lu_rs1 got=%h exp=0000dead", ifc.EX_RS1); end
  endtask

  task automatic test_wb_forward();
    set_idle();
    ifc.WB_RD_ADDR = 5'd3; ifc.WB_RD_WE = 1; ifc.WB_DATA = 32'h1234;
    set_id(5'd0, 0, 32'h0, 5'd3, 1, 32'h0, 5'd8, 0, 0);
    tick();
    total++; if (ifc.EX_RS2 !== 32'h1234) begin bad++; $display("FAIL wbfwd_rs2 got=%h exp=00001234", ifc.EX_RS2); end
  endtask

  task automatic test_x0();
    set_idle();
    set_id(5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 1, 1);
    tick();
    ifc.EX_ALU_RESULT = 32'hFFFF_FFFF;
    ifc.MEM_RD_ADDR = 0; ifc.MEM_RD_WE = 1; ifc.MEM_FWD_VALID = 0; ifc.MEM_FWD_DATA = 32'hFFFF_FFFF;
    ifc.WB_RD_ADDR = 0; ifc.WB_RD_WE = 1; ifc.WB_DATA = 32'hFFFF_FFFF;
    set_id(5'd0, 1, 32'hFFFF_FFFF, 5'd0, 1, 32'hFFFF_FFFF, 5'd4, 0, 0);
    #1;
    total++; if (ifc.ID_STALL !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b exp=0", ifc.ID_STALL); end
    tick();
    total++; if (ifc.EX_RS1 !== 32'h0) begin bad++; $display("FAIL x0_rs1 got=%h exp=00000000", ifc.EX_RS1); end
    total++; if (ifc.EX_RS2 !== 32'h0) begin bad++; $display("FAIL x0_rs2 got=%h exp=00000000", ifc.EX_RS2); end
    total++; if (ifc.EX_VALID !== 1'b1) begin bad++; $display("FAIL x0_valid got=%b exp=1", ifc.EX_VALID); end
  endtask

  task automatic test_priority();
    set_idle();
    set_id(5'd0, 0, 0, 5'd0, 0, 0, 5'd9, 1, 0);
    tick();
    ifc.EX_ALU_RESULT = 32'hA;
    ifc.WB_RD_ADDR = 5'd9; ifc.WB_RD_WE = 1; ifc.WB_DATA = 32'hB;
    set_id(5'd9, 1, 32'h0, 5'd0, 0, 32'h0, 5'd1, 0, 0);
    tick();
    total++; if (ifc.EX_RS1 !== 32'hA) begin bad++; $display("FAIL prio_ex_rs1 got=%h exp=0000000a", ifc.EX_RS1); end
    set_id(5'd0, 0, 0, 5'd0, 0, 0, 5'd9, 1, 0);
    ifc.ID_VALID = 0;
    tick();
    total++; if (ifc.EX_VALID !== 1'b0) begin bad++; $display("FAIL prio_invalid got=%b exp=0", ifc.EX_VALID); end
    set_id(5'd9, 1, 32'h0, 5'd0, 0, 32'h0, 5'd1, 0, 0);
    tick();
    total++; if (ifc.EX_RS1 !== 32'hB) begin bad++; $display("FAIL prio_wb_rs1 got=%h exp=0000000b", ifc.EX_RS1); end
  endtask

  task automatic test_backpressure_flush();
    set_idle();
    set_id(5'd2, 1, 32'h77, 5'd0, 0, 32'h0, 5'd7, 1, 0);
    ifc.ID_PC = 32'h100; ifc.ID_IMM = 32'h55;
    tick();
    set_id(5'd1, 1, 32'h88, 5'd0, 0, 32'h0, 5'd3, 1, 0);
    ifc.ID_PC = 32'h200; ifc.ID_IMM = 32'h66;
    ifc.EX_READY = 0;
    #1;
    total++; if (ifc.ID_STALL !== 1'b1) begin bad++; $display("FAIL bp_stall1 got=%b exp=1", ifc.ID_STALL); end
    tick();
    total++;
    if ({ifc.EX_VALID, ifc.EX_PC, ifc.EX_IMM, ifc.EX_RS1} !== {1'b1, 32'h100, 32'h55, 32'h77}) begin
      bad++; $display("FAIL bp_hold got vld=%b pc=%h imm=%h rs1=%h exp 1/100/55/77", ifc.EX_VALID, ifc.EX_PC, ifc.EX_IMM, ifc.EX_RS1);
    end
    ifc.FLUSH = 1;
    #1;
    total++; if (ifc.ID_STALL !== 1'b0) begin bad++; $display("FAIL bp_flush_stall got=%b exp=0", ifc.ID_STALL); end
    tick();
    total++; if (ifc.EX_VALID !== 1'b0) begin bad++; $display("FAIL bp_flush_valid got=%b exp=0", ifc.EX_VALID); end
    ifc.FLUSH = 0;
    #1;
    total++; if (ifc.ID_STALL !== 1'b1) begin bad++; $display("FAIL bp_stall3 got=%b exp=1", ifc.ID_STALL); end
    tick();
    total++; if (ifc.EX_PC !== 32'h100) begin bad++; $display("FAIL bp_hold_pc got=%h exp=00000100", ifc.EX_PC); end
    RST = 1;
    #1;
    total++; if (ifc.ID_STALL !== 1'b0) begin bad++; $display("FAIL bp_rst_stall got=%b exp=0", ifc.ID_STALL); end
    tick();
    total++;
    if ({ifc.EX_VALID, ifc.EX_RS1, ifc.EX_PC, ifc.EX_IMM, ifc.EX_RD_ADDR, ifc.EX_RD_WE} !== '0) begin
      bad++; $display("FAIL bp_rst_outputs got vld=%b rs1=%h pc=%h imm=%h exp all zero", ifc.EX_VALID, ifc.EX_RS1, ifc.EX_PC, ifc.EX_IMM);
    end
    RST = 0;
    set_idle();
  endtask

  // Sources are listed in priority order; scanning from the lowest upward lets the
  // highest-priority hit overwrite the rest.
  task automatic model_operand(input logic [4:0] rs, input logic uses, input logic [31:0] rf,
                               output logic [31:0] d, output logic haz);
    logic        hit [3];
    logic        rdy [3];
    logic [31:0] dat [3];
    hit[0] = m_vld && m_we && (m_rd == rs);       rdy[0] = !m_ld;             dat[0] = ifc.EX_ALU_RESULT;
    hit[1] = ifc.MEM_RD_WE && (ifc.MEM_RD_ADDR == rs); rdy[1] = ifc.MEM_FWD_VALID; dat[1] = ifc.MEM_FWD_DATA;
    hit[2] = ifc.WB_RD_WE && (ifc.WB_RD_ADDR == rs);   rdy[2] = 1'b1;              dat[2] = ifc.WB_DATA;
    d = rf;
    haz = 1'b0;
    if (rs == 5'd0) begin
      d = 32'h0;
    end else begin
      for (int i = 2; i >= 0; i--) begin
        if (hit[i]) begin
          d = dat[i];
          haz = uses && !rdy[i];
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d1, d2;
    logic        h1, h2, haz, exp_stall;
    RST = 1; set_idle(); tick();
    RST = 0;
    m_vld = 0; m_rs1 = 0; m_rs2 = 0; m_pc = 0; m_imm = 0; m_rd = 0; m_we = 0; m_ld = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      RST = ($urandom_range(0, 49) == 0);
      ifc.ID_VALID = ($urandom_range(0, 9) != 0);
      ifc.ID_RS1_ADDR = 5'($urandom_range(0, 3)); ifc.ID_RS2_ADDR = 5'($urandom_range(0, 3));
      ifc.ID_USES_RS1 = 1'($urandom); ifc.ID_USES_RS2 = 1'($urandom);
      ifc.ID_RS1_DATA = $urandom; ifc.ID_RS2_DATA = $urandom;
      ifc.ID_RD_ADDR = 5'($urandom_range(0, 3)); ifc.ID_RD_WE = 1'($urandom);
      ifc.ID_IS_LOAD = ($urandom_range(0, 2) == 0);
      ifc.ID_PC = $urandom; ifc.ID_IMM = $urandom; ifc.EX_ALU_RESULT = $urandom;
      ifc.MEM_RD_ADDR = 5'($urandom_range(0, 3)); ifc.MEM_RD_WE = 1'($urandom);
      ifc.MEM_FWD_VALID = ($urandom_range(0, 9) < 7); ifc.MEM_FWD_DATA = $urandom;
      ifc.WB_RD_ADDR = 5'($urandom_range(0, 3)); ifc.WB_RD_WE = 1'($urandom); ifc.WB_DATA = $urandom;
      ifc.EX_READY = ($urandom_range(0, 9) < 8); ifc.FLUSH = ($urandom_range(0, 9) == 0);
      #1;
      model_operand(ifc.ID_RS1_ADDR, ifc.ID_USES_RS1, ifc.ID_RS1_DATA, d1, h1);
      model_operand(ifc.ID_RS2_ADDR, ifc.ID_USES_RS2, ifc.ID_RS2_DATA, d2, h2);
      haz = ifc.ID_VALID && (h1 || h2);
      exp_stall = !RST && ifc.ID_VALID && !ifc.FLUSH && (haz || !ifc.EX_READY);
      total++;
      if (ifc.ID_STALL !== exp_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, ifc.ID_STALL, exp_stall); end
      if (RST) begin
        m_vld = 0; m_rs1 = 0; m_rs2 = 0; m_pc = 0; m_imm = 0; m_rd = 0; m_we = 0; m_ld = 0;
      end else if (ifc.FLUSH) begin
        m_vld = 0;
      end else if (!ifc.EX_READY) begin
        m_vld = m_vld;
      end else if (haz) begin
        m_vld = 0;
      end else begin
        m_vld = ifc.ID_VALID; m_rs1 = d1; m_rs2 = d2; m_pc = ifc.ID_PC; m_imm = ifc.ID_IMM;
        m_rd = ifc.ID_RD_ADDR; m_we = ifc.ID_RD_WE; m_ld = ifc.ID_IS_LOAD;
      end
      tick();
      total++;
      if (ifc.EX_VALID !== m_vld) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, ifc.EX_VALID, m_vld); end
      if (m_vld) begin
        total++;
        if ({ifc.EX_RS1, ifc.EX_RS2, ifc.EX_PC, ifc.EX_IMM, ifc.EX_RD_ADDR, ifc.EX_RD_WE, ifc.EX_IS_LOAD} !==
            {m_rs1, m_rs2, m_pc, m_imm, m_rd, m_we, m_ld}) begin
          bad++;
          $display("FAIL rnd_fields cyc=%0d got rs1=%h rs2=%h pc=%h rd=%0d we=%b ld=%b exp rs1=%h rs2=%h pc=%h rd=%0d we=%b ld=%b",
                   cyc, ifc.EX_RS1, ifc.EX_RS2, ifc.EX_PC, ifc.EX_RD_ADDR, ifc.EX_RD_WE, ifc.EX_IS_LOAD,
                   m_rs1, m_rs2, m_pc, m_rd, m_we, m_ld);
        end
      end
    end
    RST = 0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    RST = 1;
    set_idle();
    #1;
    test_reset();
    test_ex_forward();
    test_load_use();
    test_wb_forward();
    test_x0();
    test_priority();
    test_backpressure_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
